// File: rtl/tone_seq_pkg.sv
// Shared types, note codes and note-stepping helpers for the tone sequencer.
package tone_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   localparam int NUM_NOTES = 8;

   localparam logic [2:0] NOTE_DO  = 3'd0;
   localparam logic [2:0] NOTE_RE  = 3'd1;
   localparam logic [2:0] NOTE_MI  = 3'd2;
   localparam logic [2:0] NOTE_FA  = 3'd3;
   localparam logic [2:0] NOTE_SO  = 3'd4;
   localparam logic [2:0] NOTE_LA  = 3'd5;
   localparam logic [2:0] NOTE_SI  = 3'd6;
   localparam logic [2:0] NOTE_DO2 = 3'd7;

   // Scale arithmetic wraps mod NUM_NOTES, so the step past the end lands on the first note.
   function automatic logic [2:0] step_note(input logic [2:0] note, input logic descending);
      int unsigned nxt;
      nxt = (int'(note) + (descending ? NUM_NOTES - 1 : 1)) % NUM_NOTES;
      return nxt[2:0];
   endfunction

   function automatic logic [2:0] first_note(input logic descending);
      return descending ? NOTE_DO2 : NOTE_DO;
   endfunction

   function automatic logic [2:0] final_note(input logic descending);
      return descending ? NOTE_DO : NOTE_DO2;
   endfunction

endpackage

// File: rtl/tone_seq_timer.sv
// Tick counter: counts while running, clears on request or when it reaches the runtime limit.
module tone_seq_timer #(
   parameter int CW = 24
) (
   input  logic          CLOCK_50M,
   input  logic          reset,
   input  logic          clr,
   input  logic [CW-1:0] limit,
   output logic          expired
);

   logic [CW-1:0] count;

   assign expired = (count == limit);

   always_ff @(posedge CLOCK_50M) begin
      if (reset || clr || expired) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Auto-plays the 8-note scale on the tone generator, up or down, optionally looping.
// Define TONE_SEQ_GAP_EN to insert GAP_TICKS of silence between notes and at the loop wrap.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int NOTE_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 2_500_000
) (
   input  logic       CLOCK_50M,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   input  logic       dir,
   output logic [2:0] note_sel,
   output logic       tone_en,
   output logic       busy,
   output logic       done
);

   localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int CW        = $clog2(MAX_TICKS);

   seq_state_t    state;
   logic          dir_q;
   logic          expired;
   logic          timer_clr;
   logic          in_gap;
   logic [CW-1:0] limit;
   logic [2:0]    next_note;
   logic          at_last;

`ifdef TONE_SEQ_GAP_EN
   assign in_gap = (state == GAP);
`else
   assign in_gap = 1'b0;
`endif

   // The counter only runs while a note or a gap is timing; stop aborts it immediately.
   assign timer_clr = !((state == PLAY) || in_gap) || stop;
   assign limit     = in_gap ? CW'(GAP_TICKS - 1) : CW'(NOTE_TICKS - 1);
   assign next_note = step_note(note_sel, dir_q);
   assign at_last   = (note_sel == final_note(dir_q));

   tone_seq_timer #(
      .CW (CW)
   ) u_timer (
      .CLOCK_50M (CLOCK_50M),
      .reset     (reset),
      .clr       (timer_clr),
      .limit     (limit),
      .expired   (expired)
   );

   always_ff @(posedge CLOCK_50M) begin
      if (reset) begin
         state    <= IDLE;
         dir_q    <= 1'b0;
         note_sel <= NOTE_DO;
         tone_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state   <= IDLE;
            tone_en <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= PLAY;
                     dir_q    <= dir;
                     note_sel <= first_note(dir);
                     tone_en  <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
               PLAY: begin
                  if (expired) begin
                     if (at_last && !loop) begin
                        state   <= DONE;
                        tone_en <= 1'b0;
                        done    <= 1'b1;
                     end else begin
`ifdef TONE_SEQ_GAP_EN
                        state   <= GAP;
                        tone_en <= 1'b0;
`else
                        note_sel <= next_note;
`endif
                     end
                  end
               end
`ifdef TONE_SEQ_GAP_EN
               GAP: begin
                  if (expired) begin
                     state    <= PLAY;
                     note_sel <= next_note;
                     tone_en  <= 1'b1;
                  end
               end
`endif
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  tone_en <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer: expected output streams are built per run from the scale rules.
module tb_tone_sequencer;

   localparam int NT = 4;
   localparam int GT = 2;
`ifdef TONE_SEQ_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic       CLOCK_50M;
   logic       reset;
   logic       start;
   logic       stop;
   logic       loop;
   logic       dir;
   logic [2:0] note_sel;
   logic       tone_en;
   logic       busy;
   logic       done;

   int checks;
   int errors;

   // Each sample is {note_sel, tone_en, busy, done}.
   logic [5:0] q_exp[$];
   logic [5:0] obs;

   tone_sequencer #(
      .NOTE_TICKS (NT),
      .GAP_TICKS  (GT)
   ) dut (
      .CLOCK_50M (CLOCK_50M),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .loop      (loop),
      .dir       (dir),
      .note_sel  (note_sel),
      .tone_en   (tone_en),
      .busy      (busy),
      .done      (done)
   );

   initial CLOCK_50M = 1'b0;
   always #5 CLOCK_50M = ~CLOCK_50M;

   // Output stream seen after the start edge: every note held NT cycles, optional gaps,
   // then one DONE cycle and the IDLE cycle for a non-looping run.
   function automatic void build_run(input bit d, input bit lp, input int passes);
      logic [2:0] note;
      logic [2:0] last;
      q_exp.delete();
      for (int p = 0; p < passes; p++) begin
         for (int n = 0; n < 8; n++) begin
            note = d ? 3'(7 - n) : 3'(n);
            for (int t = 0; t < NT; t++) q_exp.push_back({note, 3'b110});
            if (GAP_ON && (n < 7 || lp))
               for (int t = 0; t < GT; t++) q_exp.push_back({note, 3'b010});
         end
      end
      if (!lp) begin
         last = d ? 3'd0 : 3'd7;
         q_exp.push_back({last, 3'b011});
         q_exp.push_back({last, 3'b000});
      end
   endfunction

   task automatic tick;
      @(posedge CLOCK_50M);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      loop  = 1'b0;
      dir   = 1'b0;
      tick();
      tick();
      checks++;
      if (note_sel !== 3'd0) begin errors++; $display("FAIL reset_note_sel got=%0d exp=0", note_sel); end
      checks++;
      if (tone_en !== 1'b0) begin errors++; $display("FAIL reset_tone_en got=%b exp=0", tone_en); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_scale_up;
      build_run(1'b0, 1'b0, 1);
      dir = 1'b0; loop = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < q_exp.size(); j++) begin
         obs = {note_sel, tone_en, busy, done};
         checks++;
         if (obs !== q_exp[j]) begin
            errors++;
            $display("FAIL scale_up cyc=%0d got=%b exp=%b", j, obs, q_exp[j]);
         end
         tick();
      end
   endtask

   task automatic test_loop_down;
      build_run(1'b1, 1'b1, 2);
      dir = 1'b1; loop = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < q_exp.size(); j++) begin
         obs = {note_sel, tone_en, busy, done};
         checks++;
         if (obs !== q_exp[j]) begin
            errors++;
            $display("FAIL loop_down cyc=%0d got=%b exp=%b", j, obs, q_exp[j]);
         end
         dir = ~dir;
         if (j == q_exp.size() - 1) stop = 1'b1;
         tick();
      end
      stop = 1'b0;
      obs = {note_sel, tone_en, busy, done};
      checks++;
      if (obs !== {q_exp[q_exp.size()-1][5:3], 3'b000}) begin
         errors++;
         $display("FAIL loop_stop got=%b exp=%b", obs, {q_exp[q_exp.size()-1][5:3], 3'b000});
      end
      loop = 1'b0;
      tick();
   endtask

   task automatic test_stop_note3;
      int idx;
      build_run(1'b0, 1'b0, 1);
      idx = 3 * (NT + (GAP_ON ? GT : 0)) + 1;
      dir = 1'b0; loop = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j <= idx; j++) begin
         obs = {note_sel, tone_en, busy, done};
         checks++;
         if (obs !== q_exp[j]) begin
            errors++;
            $display("FAIL stop_pre cyc=%0d got=%b exp=%b", j, obs, q_exp[j]);
         end
         if (j == idx) stop = 1'b1;
         tick();
      end
      stop = 1'b0;
      obs = {note_sel, tone_en, busy, done};
      checks++;
      if (obs !== {3'd3, 3'b000}) begin
         errors++;
         $display("FAIL stop_note3 got=%b exp=%b", obs, {3'd3, 3'b000});
      end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL stop_no_done got=%b exp=0", done); end
   endtask

   task automatic test_start_held;
      build_run(1'b0, 1'b0, 1);
      dir = 1'b0; loop = 1'b0; start = 1'b1;
      tick();
      for (int j = 0; j < q_exp.size(); j++) begin
         obs = {note_sel, tone_en, busy, done};
         checks++;
         if (obs !== q_exp[j]) begin
            errors++;
            $display("FAIL start_held cyc=%0d got=%b exp=%b", j, obs, q_exp[j]);
         end
         tick();
      end
      obs = {note_sel, tone_en, busy, done};
      checks++;
      if (obs !== {3'd0, 3'b110}) begin
         errors++;
         $display("FAIL start_held_rerun got=%b exp=%b", obs, {3'd0, 3'b110});
      end
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      int idx;
      build_run(1'b1, 1'b0, 1);
      idx = GAP_ON ? NT : 2;
      dir = 1'b1; loop = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j <= idx; j++) begin
         obs = {note_sel, tone_en, busy, done};
         checks++;
         if (obs !== q_exp[j]) begin
            errors++;
            $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", j, obs, q_exp[j]);
         end
         if (j == idx) reset = 1'b1;
         tick();
      end
      reset = 1'b0;
      obs = {note_sel, tone_en, busy, done};
      checks++;
      if (obs !== 6'b000000) begin
         errors++;
         $display("FAIL reset_mid got=%b exp=%b", obs, 6'b000000);
      end
      dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      obs = {note_sel, tone_en, busy, done};
      checks++;
      if (obs !== {3'd0, 3'b110}) begin
         errors++;
         $display("FAIL reset_restart got=%b exp=%b", obs, {3'd0, 3'b110});
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
   endtask

   task automatic test_random_runs;
      bit d;
      bit lp;
      int stop_at;
      for (int r = 0; r < 8; r++) begin
         d  = 1'($urandom % 2);
         lp = 1'($urandom % 2);
         build_run(d, lp, lp ? 2 : 1);
         if (lp || ($urandom % 2 == 1)) stop_at = $urandom_range(0, q_exp.size() - 1);
         else stop_at = -1;
         dir = d; loop = lp; start = 1'b1;
         tick();
         start = 1'b0;
         for (int j = 0; j < q_exp.size(); j++) begin
            obs = {note_sel, tone_en, busy, done};
            checks++;
            if (obs !== q_exp[j]) begin
               errors++;
               $display("FAIL random run=%0d cyc=%0d got=%b exp=%b", r, j, obs, q_exp[j]);
            end
            dir   = 1'($urandom % 2);
            start = 1'($urandom % 2) && (j < q_exp.size() - 2);
            if (j == stop_at) begin
               stop = 1'b1;
               tick();
               stop  = 1'b0;
               start = 1'b0;
               obs = {note_sel, tone_en, busy, done};
               checks++;
               if (obs !== {q_exp[j][5:3], 3'b000}) begin
                  errors++;
                  $display("FAIL random_stop run=%0d got=%b exp=%b", r, obs, {q_exp[j][5:3], 3'b000});
               end
               break;
            end
            tick();
         end
         start = 1'b0;
         loop  = 1'b0;
         tick();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
      loop   = 1'b0;
      dir    = 1'b0;
      test_reset();
      test_scale_up();
      test_loop_down();
      test_stop_note3();
      test_start_held();
      test_reset_mid();
      test_random_runs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
